// File: rtl/dbus_arbiter_if.sv
// femto data-bus signal bundle shared by the masters and the arbitrated slave port.
// Bus widths come from XLEN, BUS_WIDTH and BUS_ACC_CNT; the fallbacks below apply when unset.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

interface dbus_arbiter_if;
  logic                             req;
  logic [`XLEN-1:0]                 addr;
  logic                             w_rb;
  logic [$clog2(`BUS_ACC_CNT)-1:0]  acc;
  logic [`BUS_WIDTH-1:0]            wdata;
  logic                             resp;
  logic [`BUS_WIDTH-1:0]            rdata;

  modport master (output req, addr, w_rb, acc, wdata, input resp, rdata);
  modport slave  (input req, addr, w_rb, acc, wdata, output resp, rdata);
endinterface

// File: rtl/dbus_arbiter.sv
// Round-robin two-master arbiter for the femto data bus, zero-latency grant in idle.
// Optional owner timeout is compiled in with DBUS_ARB_TIMEOUT_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

module dbus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           rstn,
  dbus_arbiter_if.slave  m0,
  dbus_arbiter_if.slave  m1,
  dbus_arbiter_if.master s,
  output logic           arb_owner,
  output logic           arb_fault
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   sel, active, done, expire, finish;

  always_comb begin
    sel    = ~last_grant_q;
    active = 1'b0;
    case (state_q)
      StOwn0: begin
        sel    = 1'b0;
        active = 1'b1;
      end
      StOwn1: begin
        sel    = 1'b1;
        active = 1'b1;
      end
      default: begin
        active = m0.req | m1.req;
        if (m0.req && m1.req) sel = ~last_grant_q;
        else if (m0.req)      sel = 1'b0;
        else if (m1.req)      sel = 1'b1;
      end
    endcase
  end

  // Slave side follows the selected master; s_req tracks its req even after ownership is taken.
  assign s.req   = active & (sel ? m1.req : m0.req);
  assign s.addr  = sel ? m1.addr  : m0.addr;
  assign s.w_rb  = sel ? m1.w_rb  : m0.w_rb;
  assign s.acc   = sel ? m1.acc   : m0.acc;
  assign s.wdata = sel ? m1.wdata : m0.wdata;

  assign done = active & s.resp;

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            owning;

  assign owning = (state_q != StIdle);
  assign expire = owning & ~s.resp & (cnt_q == CntLast);

  always_comb begin
    cnt_d = '0;
    if (owning && !s.resp && !expire) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  assign finish    = done | expire;
  assign m0.resp   = finish & ~sel;
  assign m1.resp   = finish & sel;
  // A forced completion returns zero data rather than whatever the hung slave drives.
  assign m0.rdata  = expire ? '0 : s.rdata;
  assign m1.rdata  = expire ? '0 : s.rdata;
  assign arb_owner = sel;
  assign arb_fault = expire;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (finish) begin
      state_d      = StIdle;
      last_grant_d = sel;
    end else if (state_q == StIdle && active) begin
      state_d = sel ? StOwn1 : StOwn0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a round-robin ownership model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

module tb_dbus_arbiter;
`ifdef DBUS_ARB_TIMEOUT_EN
  localparam int unsigned To = 8;
  localparam bit ToEn = 1'b1;
`else
  localparam int unsigned To = 256;
  localparam bit ToEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic arb_owner, arb_fault;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dbus_arbiter_if m0_if ();
  dbus_arbiter_if m1_if ();
  dbus_arbiter_if s_if ();

  dbus_arbiter #(.TIMEOUT_CYCLES(To)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .m0       (m0_if),
    .m1       (m1_if),
    .s        (s_if),
    .arb_owner(arb_owner),
    .arb_fault(arb_fault)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 none), who was served last, how long the owner has waited.
  int m_owner = -1;
  bit m_lg = 1'b1;
  int m_cnt = 0;
  bit model_on = 1'b0;
  int n_owner, n_cnt;
  bit n_lg;

  always @(negedge clk) begin
    if (model_on) begin
      bit r0, r1, sr, act, forced, fin, exp_sreq;
      int sel;
      r0 = m0_if.req;
      r1 = m1_if.req;
      sr = s_if.resp;
      if (m_owner >= 0) begin
        sel = m_owner;
        act = 1'b1;
      end else begin
        act = r0 | r1;
        if (r0 && r1) sel = m_lg ? 0 : 1;
        else if (r0)  sel = 0;
        else if (r1)  sel = 1;
        else          sel = m_lg ? 0 : 1;
      end
      forced   = ToEn && m_owner >= 0 && !sr && m_cnt == int'(To) - 1;
      fin      = act && (sr || forced);
      exp_sreq = act && (sel == 1 ? r1 : r0);
      chk("model s_req", s_if.req, exp_sreq);
      chk("model arb_owner", arb_owner, sel[0]);
      chk("model m0_resp", m0_if.resp, fin && sel == 0);
      chk("model m1_resp", m1_if.resp, fin && sel == 1);
      chk("model arb_fault", arb_fault, forced);
      if (exp_sreq) begin
        chk("model s_addr", s_if.addr, sel == 1 ? m1_if.addr : m0_if.addr);
        chk("model s_wdata", s_if.wdata, sel == 1 ? m1_if.wdata : m0_if.wdata);
        chk("model s_w_rb", s_if.w_rb, sel == 1 ? m1_if.w_rb : m0_if.w_rb);
        chk("model s_acc", s_if.acc, sel == 1 ? m1_if.acc : m0_if.acc);
      end
      if (fin) begin
        chk("model rdata", sel == 1 ? m1_if.rdata : m0_if.rdata, forced ? '0 : s_if.rdata);
        n_owner = -1;
        n_lg    = sel[0];
        n_cnt   = 0;
      end else begin
        n_lg    = m_lg;
        n_owner = (m_owner < 0) ? (act ? sel : -1) : m_owner;
        n_cnt   = (m_owner < 0) ? 0 : m_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rstn) begin
      m_owner  = -1;
      m_lg     = 1'b1;
      m_cnt    = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      m_owner = n_owner;
      m_lg    = n_lg;
      m_cnt   = n_cnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    m0_if.req = 1'b0; m0_if.addr = '0; m0_if.w_rb = 1'b0; m0_if.acc = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.addr = '0; m1_if.w_rb = 1'b0; m1_if.acc = '0; m1_if.wdata = '0;
    s_if.resp = 1'b0; s_if.rdata = '0;
  endtask

  task automatic do_reset();
    tick();
    quiet();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  bit got0, got1, zw;

  initial begin
    rstn = 1'b0;
    quiet();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset s_req", s_if.req, 1'b0);
    chk("reset m0_resp", m0_if.resp, 1'b0);
    chk("reset m1_resp", m1_if.resp, 1'b0);
    chk("reset arb_fault", arb_fault, 1'b0);
    chk("reset arb_owner", arb_owner, 1'b0);
    tick();
    rstn = 1'b1;

    // Single m0 read, slave answers two cycles after the grant.
    tick();
    m0_if.req = 1'b1; m0_if.addr = 32'h2000_0000; m0_if.acc = 2'd2;
    @(negedge clk);
    chk("rd s_addr", s_if.addr, 32'h2000_0000);
    chk("rd s_req", s_if.req, 1'b1);
    tick();
    @(negedge clk);
    chk("rd wait m0_resp", m0_if.resp, 1'b0);
    tick();
    s_if.resp = 1'b1; s_if.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd m0_resp", m0_if.resp, 1'b1);
    chk("rd m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    chk("rd m1_resp", m1_if.resp, 1'b0);
    tick();
    m0_if.req = 1'b0; s_if.resp = 1'b0;
    @(negedge clk);
    chk("rd back idle", s_if.req, 1'b0);

    // Both masters contend continuously: grants alternate starting with m0.
    do_reset();
    m0_if.req = 1'b1; m0_if.addr = 32'h100;
    m1_if.req = 1'b1; m1_if.addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr grant", arb_owner, k % 2);
      tick();
      s_if.resp = 1'b1;
      @(negedge clk);
      chk("rr resp", (k % 2) ? m1_if.resp : m0_if.resp, 1'b1);
      tick();
      s_if.resp = 1'b0;
    end

    // m1 owns with a slow slave; m0 arriving mid-transaction waits its turn.
    do_reset();
    m1_if.req = 1'b1; m1_if.addr = 32'hAAAA_0000;
    for (int i = 0; i <= 5; i++) begin
      if (i == 2) begin
        m0_if.req = 1'b1; m0_if.addr = 32'h5555_0000;
      end
      if (i == 5) s_if.resp = 1'b1;
      @(negedge clk);
      chk("hold s_addr", s_if.addr, 32'hAAAA_0000);
      tick();
    end
    m1_if.req = 1'b0; s_if.resp = 1'b0;
    @(negedge clk);
    chk("after hold owner", arb_owner, 1'b0);
    chk("after hold s_addr", s_if.addr, 32'h5555_0000);

    // Zero-wait slave: owners alternate every cycle once both request.
    do_reset();
    m0_if.req = 1'b1;
    #1 s_if.resp = s_if.req;
    @(negedge clk);
    chk("zw m0_resp", m0_if.resp, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      m1_if.req = 1'b1;
      #1 s_if.resp = s_if.req;
      @(negedge clk);
      chk("zw owner", arb_owner, (i % 2) ? 1'b0 : 1'b1);
    end

    // Reset pulsed while m1 owns: in-flight response dropped, m0 wins next tie.
    do_reset();
    m1_if.req = 1'b1; m1_if.addr = 32'h1111;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m0_if.req = 1'b1; m0_if.addr = 32'h2222;
    @(negedge clk);
    chk("rst owner", arb_owner, 1'b0);
    chk("rst s_addr", s_if.addr, 32'h2222);
    chk("rst m1_resp", m1_if.resp, 1'b0);

`ifdef DBUS_ARB_TIMEOUT_EN
    // Hung slave: forced completion To cycles after the grant, then m1 is served.
    do_reset();
    m0_if.req = 1'b1; s_if.rdata = 32'hFFFF_FFFF;
    tick();
    m1_if.req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("to m0_resp", m0_if.resp, i == 8);
      chk("to arb_fault", arb_fault, i == 8);
      if (i == 8) chk("to m0_rdata", m0_if.rdata, 32'h0);
      tick();
    end
    m0_if.req = 1'b0;
    @(negedge clk);
    chk("to next owner", arb_owner, 1'b1);
    chk("to next s_req", s_if.req, 1'b1);
`endif

    // Random traffic against the model.
    do_reset();
    got0 = 1'b0; got1 = 1'b0; zw = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 250) zw = ~zw;
      if (m0_if.req ? got0 : 1'b1) begin
        m0_if.req = ($urandom_range(1) == 0);
        m0_if.addr = $urandom; m0_if.w_rb = $urandom_range(1);
        m0_if.acc = 2'($urandom_range(3)); m0_if.wdata = $urandom;
      end
      if (m1_if.req ? got1 : 1'b1) begin
        m1_if.req = ($urandom_range(1) == 0);
        m1_if.addr = $urandom; m1_if.w_rb = $urandom_range(1);
        m1_if.acc = 2'($urandom_range(3)); m1_if.wdata = $urandom;
      end
      #1;
      if (s_if.req) s_if.resp = zw ? 1'b1 : ($urandom_range(2) == 0);
      else          s_if.resp = ($urandom_range(7) == 0);
      s_if.rdata = $urandom;
      @(negedge clk);
      got0 = m0_if.resp;
      got1 = m1_if.resp;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
